// File: rtl/cpu_mem_arb_if.sv
// rtl/cpu_mem_arb_if.sv - IFU, LSU and memory port bundle for the CPU memory arbiter
// slave is the arbiter's view; master is the surrounding core and memory.
interface cpu_mem_arb_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  i_ifu_req_valid;
  logic                  o_ifu_req_ready;
  logic [DATA_WIDTH-1:0] i_ifu_req_addr;
  logic                  o_ifu_resp_valid;
  logic [DATA_WIDTH-1:0] o_ifu_resp_data;
  logic                  o_ifu_resp_err;

  logic                  i_lsu_req_valid;
  logic                  o_lsu_req_ready;
  logic                  i_lsu_req_wen;
  logic [DATA_WIDTH-1:0] i_lsu_req_addr;
  logic [DATA_WIDTH-1:0] i_lsu_req_wdata;
  logic [MASK_WIDTH-1:0] i_lsu_req_wmask;
  logic                  o_lsu_resp_valid;
  logic [DATA_WIDTH-1:0] o_lsu_resp_data;
  logic                  o_lsu_resp_err;

  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic                  o_mem_req_wen;
  logic [DATA_WIDTH-1:0] o_mem_req_addr;
  logic [DATA_WIDTH-1:0] o_mem_req_wdata;
  logic [MASK_WIDTH-1:0] o_mem_req_wmask;
  logic                  i_mem_resp_valid;
  logic [DATA_WIDTH-1:0] i_mem_resp_data;

  modport slave (
    input  i_ifu_req_valid, i_ifu_req_addr,
    input  i_lsu_req_valid, i_lsu_req_wen, i_lsu_req_addr, i_lsu_req_wdata, i_lsu_req_wmask,
    input  i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data,
    output o_ifu_req_ready, o_ifu_resp_valid, o_ifu_resp_data, o_ifu_resp_err,
    output o_lsu_req_ready, o_lsu_resp_valid, o_lsu_resp_data, o_lsu_resp_err,
    output o_mem_req_valid, o_mem_req_wen, o_mem_req_addr, o_mem_req_wdata, o_mem_req_wmask
  );

  modport master (
    output i_ifu_req_valid, i_ifu_req_addr,
    output i_lsu_req_valid, i_lsu_req_wen, i_lsu_req_addr, i_lsu_req_wdata, i_lsu_req_wmask,
    output i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data,
    input  o_ifu_req_ready, o_ifu_resp_valid, o_ifu_resp_data, o_ifu_resp_err,
    input  o_lsu_req_ready, o_lsu_resp_valid, o_lsu_resp_data, o_lsu_resp_err,
    input  o_mem_req_valid, o_mem_req_wen, o_mem_req_addr, o_mem_req_wdata, o_mem_req_wmask
  );
endinterface

// File: rtl/cpu_mem_arb.sv
// rtl/cpu_mem_arb.sv - single-outstanding IFU/LSU arbiter for the CPU memory port
// One request is latched, issued with valid/ready, and its response (or watchdog error) routed back.
module cpu_mem_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit LSU_PRIO       = 1'b0
) (
  input logic          i_sys_clk,
  input logic          i_sys_rst_n,
  cpu_mem_arb_if.slave bus
);
  localparam int MW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q;
  logic                  owner_lsu_q;
  logic                  last_lsu_q;
  logic [CW-1:0]         cnt_q;
  logic                  mem_valid_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         wmask_q;
  logic                  ifu_resp_valid_q;
  logic [DATA_WIDTH-1:0] ifu_resp_data_q;
  logic                  ifu_resp_err_q;
  logic                  lsu_resp_valid_q;
  logic [DATA_WIDTH-1:0] lsu_resp_data_q;
  logic                  lsu_resp_err_q;

  logic                  idle;
  logic                  grant_lsu_d;
  logic                  accept_d;
  logic                  timeout_d;
  logic                  deliver_d;
  logic [DATA_WIDTH-1:0] resp_data_d;
  logic                  resp_err_d;

  // Round-robin: on a tie the requester that did not win last time goes first.
  assign idle        = (state_q == S_IDLE);
  assign grant_lsu_d = bus.i_lsu_req_valid &&
                       (LSU_PRIO || !bus.i_ifu_req_valid || !last_lsu_q);
  assign accept_d    = idle && (bus.i_ifu_req_valid || bus.i_lsu_req_valid);

  assign bus.o_lsu_req_ready = idle && grant_lsu_d;
  assign bus.o_ifu_req_ready = idle && bus.i_ifu_req_valid && !grant_lsu_d;

  // A real response takes precedence over a watchdog expiring in the same cycle.
  assign timeout_d   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign deliver_d   = (state_q == S_WAIT) && (bus.i_mem_resp_valid || timeout_d);
  assign resp_err_d  = !bus.i_mem_resp_valid;
  assign resp_data_d = (bus.i_mem_resp_valid && !wen_q) ? bus.i_mem_resp_data : '0;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_q          <= S_IDLE;
      owner_lsu_q      <= 1'b0;
      last_lsu_q       <= 1'b0;
      cnt_q            <= '0;
      mem_valid_q      <= 1'b0;
      wen_q            <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            owner_lsu_q <= grant_lsu_d;
            last_lsu_q  <= grant_lsu_d;
            wen_q       <= grant_lsu_d && bus.i_lsu_req_wen;
            addr_q      <= grant_lsu_d ? bus.i_lsu_req_addr : bus.i_ifu_req_addr;
            wdata_q     <= grant_lsu_d ? bus.i_lsu_req_wdata : '0;
            wmask_q     <= grant_lsu_d ? bus.i_lsu_req_wmask : '1;
            mem_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.i_mem_req_ready) begin
            mem_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (deliver_d) begin
            state_q <= S_IDLE;
            if (owner_lsu_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_resp_data_q  <= resp_data_d;
              lsu_resp_err_q   <= resp_err_d;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_resp_data_q  <= resp_data_d;
              ifu_resp_err_q   <= resp_err_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_mem_req_valid  = mem_valid_q;
  assign bus.o_mem_req_wen    = wen_q;
  assign bus.o_mem_req_addr   = addr_q;
  assign bus.o_mem_req_wdata  = wdata_q;
  assign bus.o_mem_req_wmask  = wmask_q;
  assign bus.o_ifu_resp_valid = ifu_resp_valid_q;
  assign bus.o_ifu_resp_data  = ifu_resp_data_q;
  assign bus.o_ifu_resp_err   = ifu_resp_err_q;
  assign bus.o_lsu_resp_valid = lsu_resp_valid_q;
  assign bus.o_lsu_resp_data  = lsu_resp_data_q;
  assign bus.o_lsu_resp_err   = lsu_resp_err_q;
endmodule

// File: tb/tb_cpu_mem_arb.sv
// tb/tb_cpu_mem_arb.sv - vector table plus directed sequences for cpu_mem_arb
// dut0 is round-robin, dut1 is fixed LSU priority; both use an 8-cycle watchdog.
module tb_cpu_mem_arb;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_arb_if #(.DATA_WIDTH(32)) b0 ();
  cpu_mem_arb_if #(.DATA_WIDTH(32)) b1 ();

  cpu_mem_arb #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .LSU_PRIO(1'b0)) dut0 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(b0));
  cpu_mem_arb #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .LSU_PRIO(1'b1)) dut1 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(b1));

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rdy_dly;
    int          resp_dly;
    logic [31:0] rdata;
    bit          e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    int          e_lat;
    logic [31:0] e_data;
    bit          e_err;
  } vec_t;

  vec_t vt[7];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic nz0();
    return |{b0.o_mem_req_valid, b0.o_mem_req_wen, b0.o_mem_req_addr, b0.o_mem_req_wdata,
             b0.o_mem_req_wmask, b0.o_ifu_req_ready, b0.o_lsu_req_ready,
             b0.o_ifu_resp_valid, b0.o_ifu_resp_data, b0.o_ifu_resp_err,
             b0.o_lsu_resp_valid, b0.o_lsu_resp_data, b0.o_lsu_resp_err};
  endfunction

  function automatic logic nz1();
    return |{b1.o_mem_req_valid, b1.o_mem_req_wen, b1.o_mem_req_addr, b1.o_mem_req_wdata,
             b1.o_mem_req_wmask, b1.o_ifu_req_ready, b1.o_lsu_req_ready,
             b1.o_ifu_resp_valid, b1.o_ifu_resp_data, b1.o_ifu_resp_err,
             b1.o_lsu_resp_valid, b1.o_lsu_resp_data, b1.o_lsu_resp_err};
  endfunction

  task automatic idle_inputs();
    b0.i_ifu_req_valid = 1'b0; b0.i_ifu_req_addr  = '0;
    b0.i_lsu_req_valid = 1'b0; b0.i_lsu_req_wen   = 1'b0;
    b0.i_lsu_req_addr  = '0;   b0.i_lsu_req_wdata = '0; b0.i_lsu_req_wmask = '0;
    b0.i_mem_req_ready = 1'b0; b0.i_mem_resp_valid = 1'b0; b0.i_mem_resp_data = '0;
    b1.i_ifu_req_valid = 1'b0; b1.i_ifu_req_addr  = '0;
    b1.i_lsu_req_valid = 1'b0; b1.i_lsu_req_wen   = 1'b0;
    b1.i_lsu_req_addr  = '0;   b1.i_lsu_req_wdata = '0; b1.i_lsu_req_wmask = '0;
    b1.i_mem_req_ready = 1'b0; b1.i_mem_resp_valid = 1'b0; b1.i_mem_resp_data = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat = -1;
    int          req_cycles = 0;
    int          k = 0;
    bit          hs = 1'b0;
    bit          fields_ok = 1'b1;
    bit          other = 1'b0;
    bit          extra = 1'b0;
    logic [31:0] rd = '0;
    logic        re = 1'b0;
    logic        own;
    logic        oth;
    step();
    if (v.lsu) begin
      b0.i_lsu_req_valid = 1'b1; b0.i_lsu_req_wen = v.wen; b0.i_lsu_req_addr = v.addr;
      b0.i_lsu_req_wdata = v.wdata; b0.i_lsu_req_wmask = v.wmask;
    end else begin
      b0.i_ifu_req_valid = 1'b1; b0.i_ifu_req_addr = v.addr;
    end
    #1;
    chk($sformatf("v%0d_accept", idx), {31'b0, v.lsu ? b0.o_lsu_req_ready : b0.o_ifu_req_ready}, 32'd1);
    for (int c = 1; c <= 40; c++) begin
      step();
      b0.i_ifu_req_valid  = 1'b0;
      b0.i_lsu_req_valid  = 1'b0;
      b0.i_ifu_req_addr   = ~v.addr;
      b0.i_lsu_req_addr   = ~v.addr;
      b0.i_lsu_req_wdata  = ~v.wdata;
      b0.i_mem_req_ready  = !hs && (req_cycles >= v.rdy_dly);
      b0.i_mem_resp_valid = hs && (lat < 0) && (k == v.resp_dly);
      b0.i_mem_resp_data  = v.rdata;
      #1;
      if (lat < 0) begin
        if (!hs)
          fields_ok = fields_ok && b0.o_mem_req_valid && (b0.o_mem_req_wen == v.e_wen) &&
                      (b0.o_mem_req_addr == v.addr) && (b0.o_mem_req_wdata == v.e_wdata) &&
                      (b0.o_mem_req_wmask == v.e_wmask);
        else
          fields_ok = fields_ok && !b0.o_mem_req_valid;
      end
      own = v.lsu ? b0.o_lsu_resp_valid : b0.o_ifu_resp_valid;
      oth = v.lsu ? b0.o_ifu_resp_valid : b0.o_lsu_resp_valid;
      if (own) begin
        if (lat < 0) begin
          lat = c;
          rd  = v.lsu ? b0.o_lsu_resp_data : b0.o_ifu_resp_data;
          re  = v.lsu ? b0.o_lsu_resp_err : b0.o_ifu_resp_err;
        end else begin
          extra = 1'b1;
        end
      end
      if (oth) other = 1'b1;
      if (!hs) begin
        if (b0.i_mem_req_ready) hs = 1'b1;
        else req_cycles++;
      end else begin
        k++;
      end
      if (lat >= 0 && c > lat) break;
    end
    b0.i_mem_resp_valid = 1'b0;
    b0.i_mem_req_ready  = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d_data", idx), rd, v.e_data);
    chk($sformatf("v%0d_err", idx), {31'b0, re}, {31'b0, v.e_err});
    chk($sformatf("v%0d_mem_fields", idx), {31'b0, fields_ok}, 32'd1);
    chk($sformatf("v%0d_nonowner_pulse", idx), {31'b0, other}, 32'd0);
    chk($sformatf("v%0d_pulse_width", idx), {31'b0, extra}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          g0[4];
    int          g1[4];
    int          a0[4];
    int          a1[4];
    int          n0 = 0, n1 = 0, ip0 = 0, lp0 = 0, ip1 = 0, lp1 = 0;
    logic        mv0 = 1'b0, mv1 = 1'b0;

    //       lsu wen addr          wdata         wmask  rdy rsp rdata         e_wen e_wdata       e_wmask lat e_data        err
    vt[0] = '{0, 0, 32'h0000_1000, 32'h0,        4'hF,  0,  0,  32'hDEAD_BEEF, 0,  32'h0,        4'hF,   3, 32'hDEAD_BEEF, 0};
    vt[1] = '{1, 1, 32'h0000_2004, 32'h1234_5678, 4'h3, 3,  0,  32'hFFFF_FFFF, 1,  32'h1234_5678, 4'h3,   6, 32'h0,        0};
    vt[2] = '{1, 0, 32'h0000_3008, 32'hAAAA_5555, 4'hF, 1,  2,  32'h0BAD_F00D, 0,  32'hAAAA_5555, 4'hF,   6, 32'h0BAD_F00D, 0};
    vt[3] = '{0, 0, 32'h0000_1004, 32'h0,        4'hF,  0,  6,  32'h1357_9BDF, 0,  32'h0,        4'hF,   9, 32'h1357_9BDF, 0};
    vt[4] = '{0, 0, 32'h0000_1008, 32'h0,        4'hF,  0,  7,  32'h2468_ACE0, 0,  32'h0,        4'hF,  10, 32'h2468_ACE0, 0};
    vt[5] = '{1, 1, 32'h0000_4000, 32'hCAFE_BABE, 4'hC, 2,  99, 32'h7777_7777, 1,  32'hCAFE_BABE, 4'hC,  12, 32'h0,        1};
    vt[6] = '{0, 0, 32'h0000_100C, 32'h0,        4'hF,  0,  99, 32'h5555_5555, 0,  32'h0,        4'hF,  10, 32'h0,        1};

    idle_inputs();
    repeat (3) step();
    chk("reset_outs_dut0", {31'b0, nz0()}, 32'd0);
    chk("reset_outs_dut1", {31'b0, nz1()}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Stray memory response while idle must not produce a pulse.
    step();
    b0.i_mem_resp_valid = 1'b1; b0.i_mem_resp_data = 32'h9999_9999;
    #1;
    step();
    b0.i_mem_resp_valid = 1'b0;
    #1;
    chk("stray_ifu_pulse", {31'b0, b0.o_ifu_resp_valid}, 32'd0);
    chk("stray_lsu_pulse", {31'b0, b0.o_lsu_resp_valid}, 32'd0);

    // Reset while waiting for the memory response.
    step();
    b0.i_ifu_req_valid = 1'b1; b0.i_ifu_req_addr = 32'h0000_5000;
    #1;
    chk("rw_accept", {31'b0, b0.o_ifu_req_ready}, 32'd1);
    step();
    b0.i_ifu_req_valid = 1'b0; b0.i_mem_req_ready = 1'b1;
    #1;
    chk("rw_req_valid", {31'b0, b0.o_mem_req_valid}, 32'd1);
    step();
    b0.i_mem_req_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("rw_wait_valid_low", {31'b0, b0.o_mem_req_valid}, 32'd0);
    step();
    rst_n = 1'b1; b0.i_mem_resp_valid = 1'b1; b0.i_mem_resp_data = 32'h3333_3333;
    #1;
    chk("rw_outs_zero", {31'b0, nz0()}, 32'd0);
    step();
    b0.i_mem_resp_valid = 1'b0;
    #1;
    chk("rw_late_ifu_pulse", {31'b0, b0.o_ifu_resp_valid}, 32'd0);
    chk("rw_late_lsu_pulse", {31'b0, b0.o_lsu_resp_valid}, 32'd0);

    // Both requesters held valid: dut0 alternates starting with LSU, dut1 always LSU.
    for (int c = 0; c < 40; c++) begin
      step();
      b0.i_ifu_req_valid = (n0 < 4); b0.i_lsu_req_valid = (n0 < 4);
      b0.i_ifu_req_addr = 32'h0000_0100; b0.i_lsu_req_addr = 32'h0000_0200; b0.i_lsu_req_wen = 1'b0;
      b0.i_mem_req_ready = 1'b1; b0.i_mem_resp_valid = mv0; b0.i_mem_resp_data = 32'(c);
      b1.i_ifu_req_valid = (n1 < 4); b1.i_lsu_req_valid = (n1 < 4);
      b1.i_ifu_req_addr = 32'h0000_0100; b1.i_lsu_req_addr = 32'h0000_0200; b1.i_lsu_req_wen = 1'b0;
      b1.i_mem_req_ready = 1'b1; b1.i_mem_resp_valid = mv1; b1.i_mem_resp_data = 32'(c);
      #1;
      if (b0.o_lsu_req_ready || b0.o_ifu_req_ready) begin
        if (n0 < 4) begin g0[n0] = {b0.o_lsu_req_ready, b0.o_ifu_req_ready}; a0[n0] = c; end
        n0++;
      end
      if (b1.o_lsu_req_ready || b1.o_ifu_req_ready) begin
        if (n1 < 4) begin g1[n1] = {b1.o_lsu_req_ready, b1.o_ifu_req_ready}; a1[n1] = c; end
        n1++;
      end
      mv0 = b0.o_mem_req_valid;
      mv1 = b1.o_mem_req_valid;
      ip0 += int'(b0.o_ifu_resp_valid); lp0 += int'(b0.o_lsu_resp_valid);
      ip1 += int'(b1.o_ifu_resp_valid); lp1 += int'(b1.o_lsu_resp_valid);
    end
    chk("rr_grant_count", n0, 4);
    chk("prio_grant_count", n1, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), g0[i], (i % 2 == 0) ? 2 : 1);
      chk($sformatf("prio_grant%0d", i), g1[i], 2);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr_gap%0d", i), a0[i+1] - a0[i], 3);
      chk($sformatf("prio_gap%0d", i), a1[i+1] - a1[i], 3);
    end
    chk("rr_ifu_pulses", ip0, 2);
    chk("rr_lsu_pulses", lp0, 2);
    chk("prio_ifu_pulses", ip1, 0);
    chk("prio_lsu_pulses", lp1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_mem_arb.md
Name: cpu_mem_arb

Overview:
- Arbiter/sequencer sharing the single CPU memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time, drives it to memory with a valid/ready handshake and waits for the response.
- Routes the response back to the owning requester.
- Includes a response watchdog so a hung memory cannot deadlock the core.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- TIMEOUT_CYCLES, 256, cycles spent in WAIT before an error response is returned; 0 disables the watchdog.
- LSU_PRIO, 0, 1 = fixed LSU priority; 0 = round-robin.

Ports:
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_sys_rst_n  in  1  synchronous active-low reset.
- i_ifu_req_valid  in  1  IFU read request.
- o_ifu_req_ready  out  1  IFU request accepted this cycle.
- i_ifu_req_addr  in  DATA_WIDTH  fetch address.
- o_ifu_resp_valid  out  1  one-cycle response pulse.
- o_ifu_resp_data  out  DATA_WIDTH  fetched word.
- o_ifu_resp_err  out  1  timeout error.
- i_lsu_req_valid  in  1  LSU request.
- o_lsu_req_ready  out  1  LSU request accepted.
- i_lsu_req_wen  in  1  1 = write.
- i_lsu_req_addr  in  DATA_WIDTH  address.
- i_lsu_req_wdata  in  DATA_WIDTH  write data.
- i_lsu_req_wmask  in  DATA_WIDTH/8  byte enables.
- o_lsu_resp_valid  out  1  one-cycle response pulse (read data or write ack).
- o_lsu_resp_data  out  DATA_WIDTH  read data; 0 for writes.
- o_lsu_resp_err  out  1  timeout error.
- o_mem_req_valid  out  1  memory request.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_req_wen  out  1  write enable.
- o_mem_req_addr  out  DATA_WIDTH  address.
- o_mem_req_wdata  out  DATA_WIDTH  write data.
- o_mem_req_wmask  out  DATA_WIDTH/8  byte enables.
- i_mem_resp_valid  in  1  memory response.
- i_mem_resp_data  in  DATA_WIDTH  read data.

Behaviour:
- Reset (synchronous, i_sys_rst_n=0 at a clock edge):
  - State goes to IDLE and all outputs go to 0.
  - Latched request fields, owner and watchdog counter are cleared.
  - Last-grant is set to IFU.
  - Reset mid-transaction abandons the transaction with no response pulse; a later memory response is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Grant is computed combinationally.
    - LSU_PRIO=1: LSU wins whenever it is valid.
    - LSU_PRIO=0: when both are valid, the requester not granted last wins; a single valid requester always wins.
  - o_X_req_ready=1 only for the granted requester, and only in IDLE. Both ready signals are 0 when no request is valid.
  - On ready&valid: latch wen/addr/wdata/wmask (IFU: wen=0, wmask=all ones, wdata=0), record owner, update last-grant, go to REQ.
- REQ:
  - o_mem_req_valid=1 with the latched fields held stable.
  - On i_mem_req_ready, go to WAIT, clear the counter and drop valid on the next cycle.
  - There is no timeout in REQ.
- WAIT:
  - On i_mem_resp_valid, register a response to the owner: next cycle resp_valid=1 for exactly one cycle, with data = i_mem_resp_data (0 for writes) and err=0. State returns to IDLE.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no response (TIMEOUT_CYCLES≠0), the owner gets a one-cycle pulse with err=1 and data=0, and state goes to IDLE.
  - A response arriving on the same cycle as the timeout wins: err=0.
- i_mem_resp_valid outside WAIT is ignored.
- Response data/err are held until the next pulse; they are only meaningful while resp_valid=1.
- Latency: accept at cycle t → mem_req_valid at t+1 → with ready at t+1 and resp at t+2, resp_valid at t+3. The next accept is possible at t+3 (ready is asserted while resp_valid is high).
- Only one outstanding transaction; no pipelining or reordering.
- The non-owner requester's resp_valid is never asserted.

Test Plan:
- IFU-only read of addr 0x0000_1000; memory ready immediately, resp 0xDEAD_BEEF one cycle later → o_ifu_resp_valid pulses at t+3 with 0xDEAD_BEEF, err=0; o_lsu_resp_valid stays 0.
- LSU write addr 0x0000_2004, wdata 0x1234_5678, wmask 4'b0011; i_mem_req_ready held low 3 cycles → mem request fields stable for 4 cycles; o_lsu_resp_valid pulses with data 0.
- LSU_PRIO=0, both requesters continuously valid for 4 transactions → grants LSU, IFU, LSU, IFU. LSU_PRIO=1 → LSU, LSU, LSU, LSU.
- TIMEOUT_CYCLES=8, IFU read, memory never responds → o_ifu_resp_valid=1 with err=1, data=0, 8 cycles after entering WAIT. A stray i_mem_resp_valid afterwards produces no pulse.
- Response and timeout on the same cycle → err=0, data passed through.
- Reset asserted while in WAIT → all outputs 0 next cycle, state IDLE; a late memory response produces no pulse; a first tie after reset goes to LSU.
